// File: rtl/alu_control_fsm_if.sv
// Control-side bundle between alu_control_fsm and the 12-bit accumulator datapath.
// The master modport is the controller; the slave modport is the datapath/memory side.
interface alu_control_fsm_if;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       Zflag;
    logic [2:0] ALU_Operation;
    logic       ac_we;
    logic       ir_we;
    logic       pc_inc;
    logic       pc_load;
    logic       addr_sel;
    logic [1:0] bus_sel;
    logic       mem_read;
    logic       mem_write;
    logic       z_latched;
    logic       halted;
    logic       illegal;
    logic       bus_error;

    modport master (
        input  opcode, mem_ready, Zflag,
        output ALU_Operation, ac_we, ir_we, pc_inc, pc_load, addr_sel, bus_sel,
               mem_read, mem_write, z_latched, halted, illegal, bus_error
    );

    modport slave (
        output opcode, mem_ready, Zflag,
        input  ALU_Operation, ac_we, ir_we, pc_inc, pc_load, addr_sel, bus_sel,
               mem_read, mem_write, z_latched, halted, illegal, bus_error
    );
endinterface

// File: rtl/alu_control_fsm.sv
// Multi-cycle control unit for the 12-bit accumulator datapath: fetch/decode/operand/store/exec
// sequencing with memory ready handshake, zero-flag latch and memory-timeout bus error.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  S_FETCH  | read instruction at PC; on ready load IR and bump PC
//  S_DECODE | capture opcode, pick the operand/store/exec/halt path
//  S_OPRD   | read operand at IR[7:0]; on ready the ALU writes AC
//  S_STORE  | write AC to IR[7:0]
//  S_EXEC   | single-cycle register ops, jumps, NOP, illegal report
//  S_HALT   | parked until reset
module alu_control_fsm #(
    parameter int TIMEOUT   = 16,
    parameter int TIMEOUT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    alu_control_fsm_if.master  ctl
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_OPRD   = 3'd2,
        S_STORE  = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam bit                   TO_EN  = (TIMEOUT > 0);
    localparam logic [TIMEOUT_W-1:0] TO_LIM = TIMEOUT_W'(TIMEOUT);

    state_t               state, state_next;
    logic [3:0]           op_r;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 z_r;
    logic                 berr_r;

    logic [2:0] alu_op;
    logic       ac_we_c, ir_we_c, pc_inc_c, pc_load_c, addr_sel_c;
    logic [1:0] bus_sel_c;
    logic       mem_read_c, mem_write_c, halted_c, illegal_c;
    logic       set_berr;
    logic       timeout_hit;
    logic       in_wait_state;

    assign timeout_hit   = TO_EN && (wait_cnt == TO_LIM);
    assign in_wait_state = (state == S_FETCH) || (state == S_OPRD) || (state == S_STORE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            op_r     <= 4'h0;
            wait_cnt <= '0;
            z_r      <= 1'b0;
            berr_r   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                op_r <= ctl.opcode;
            end
            // Staying in a memory state means another wait cycle; any transition restarts the count.
            if (in_wait_state && (state_next == state)) begin
                if (wait_cnt != '1) begin
                    wait_cnt <= wait_cnt + TIMEOUT_W'(1);
                end
            end else begin
                wait_cnt <= '0;
            end
            if (ac_we_c) begin
                z_r <= ctl.Zflag;
            end
            if (set_berr) begin
                berr_r <= 1'b1;
            end
        end
    end

    // Outputs are forced quiet while reset is held so strobes drop the instant reset asserts.
    always_comb begin
        state_next  = state;
        alu_op      = 3'b000;
        ac_we_c     = 1'b0;
        ir_we_c     = 1'b0;
        pc_inc_c    = 1'b0;
        pc_load_c   = 1'b0;
        addr_sel_c  = 1'b0;
        bus_sel_c   = 2'b00;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        halted_c    = 1'b0;
        illegal_c   = 1'b0;
        set_berr    = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_read_c = 1'b1;
                    if (ctl.mem_ready) begin
                        ir_we_c    = 1'b1;
                        pc_inc_c   = 1'b1;
                        state_next = S_DECODE;
                    end else if (timeout_hit) begin
                        set_berr   = 1'b1;
                        state_next = S_HALT;
                    end
                end
                S_DECODE: begin
                    case (ctl.opcode)
                        4'h1, 4'h3, 4'h4, 4'h5: state_next = S_OPRD;
                        4'h2:                   state_next = S_STORE;
                        4'hF:                   state_next = S_HALT;
                        default:                state_next = S_EXEC;
                    endcase
                end
                S_OPRD: begin
                    mem_read_c = 1'b1;
                    addr_sel_c = 1'b1;
                    if (ctl.mem_ready) begin
                        case (op_r)
                            4'h1:    alu_op = 3'b001;
                            4'h3:    alu_op = 3'b010;
                            4'h4:    alu_op = 3'b011;
                            4'h5:    alu_op = 3'b100;
                            default: alu_op = 3'b000;
                        endcase
                        ac_we_c    = 1'b1;
                        state_next = S_FETCH;
                    end else if (timeout_hit) begin
                        set_berr   = 1'b1;
                        state_next = S_HALT;
                    end
                end
                S_STORE: begin
                    mem_write_c = 1'b1;
                    addr_sel_c  = 1'b1;
                    bus_sel_c   = 2'b01;
                    if (ctl.mem_ready) begin
                        state_next = S_FETCH;
                    end else if (timeout_hit) begin
                        set_berr   = 1'b1;
                        state_next = S_HALT;
                    end
                end
                S_EXEC: begin
                    case (op_r)
                        4'h0: ;
                        4'h6: begin
                            alu_op  = 3'b101;
                            ac_we_c = 1'b1;
                        end
                        4'h7: begin
                            alu_op  = 3'b110;
                            ac_we_c = 1'b1;
                        end
                        4'h8: begin
                            bus_sel_c = 2'b11;
                            pc_load_c = 1'b1;
                        end
                        4'h9: begin
                            bus_sel_c = 2'b11;
                            pc_load_c = z_r;
                        end
                        4'hA: begin
                            bus_sel_c = 2'b11;
                            pc_load_c = !z_r;
                        end
                        default: illegal_c = 1'b1;
                    endcase
                    state_next = S_FETCH;
                end
                S_HALT: begin
                    halted_c = 1'b1;
                end
                default: state_next = S_FETCH;
            endcase
        end
    end

    assign ctl.ALU_Operation = alu_op;
    assign ctl.ac_we         = ac_we_c;
    assign ctl.ir_we         = ir_we_c;
    assign ctl.pc_inc        = pc_inc_c;
    assign ctl.pc_load       = pc_load_c;
    assign ctl.addr_sel      = addr_sel_c;
    assign ctl.bus_sel       = bus_sel_c;
    assign ctl.mem_read      = mem_read_c;
    assign ctl.mem_write     = mem_write_c;
    assign ctl.z_latched     = z_r;
    assign ctl.halted        = halted_c;
    assign ctl.illegal       = illegal_c;
    assign ctl.bus_error     = berr_r;

endmodule

// File: tb/tb_alu_control_fsm.sv
// Bench for alu_control_fsm: per-instruction expected output traces built from the
// instruction-level rules, driven by a vector table, hand sequences and random instructions.
module tb_alu_control_fsm;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_control_fsm_if ifc ();

    alu_control_fsm #(.TIMEOUT(16), .TIMEOUT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (ifc)
    );

    typedef struct packed {
        logic [2:0] alu;
        logic       ac_we;
        logic       ir_we;
        logic       pc_inc;
        logic       pc_load;
        logic       addr_sel;
        logic [1:0] bus_sel;
        logic       mem_read;
        logic       mem_write;
        logic       z;
        logic       halted;
        logic       illegal;
        logic       berr;
    } obs_t;

    typedef struct {
        logic mr;
        obs_t exp;
    } step_t;

    typedef struct {
        logic [3:0] op;
        int         fw;
        int         ow;
        logic       zf;
        logic       exp_z;
        int         exp_pl;
    } vec_t;

    step_t      trace[$];
    int         checks = 0;
    int         errors = 0;
    logic       mz = 1'b0;
    logic       mbe = 1'b0;
    int         pl_cnt;
    logic [3:0] cur_op;
    logic       cur_zf;

    function automatic obs_t sample();
        return {ifc.ALU_Operation, ifc.ac_we, ifc.ir_we, ifc.pc_inc, ifc.pc_load, ifc.addr_sel,
                ifc.bus_sel, ifc.mem_read, ifc.mem_write, ifc.z_latched, ifc.halted,
                ifc.illegal, ifc.bus_error};
    endfunction

    function automatic obs_t mk(logic [2:0] alu, logic ac, logic ir, logic pinc, logic pl,
                                logic as, logic [1:0] bs, logic mr, logic mw, logic h, logic il);
        return {alu, ac, ir, pinc, pl, as, bs, mr, mw, mz, h, il, mbe};
    endfunction

    task automatic check(string name, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t op=%h got=%h expected=%h", name, $time, cur_op, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic push(logic mr, obs_t e);
        step_t s;
        s.mr  = mr;
        s.exp = e;
        trace.push_back(s);
    endtask

    // Expected cycle-by-cycle outputs of one instruction, from the instruction-level rules.
    task automatic build(logic [3:0] op, int fw, int ow, logic zf);
        logic [2:0] a;
        trace.delete();
        for (int i = 0; i < fw; i++) push(1'b0, mk(3'd0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0));
        push(1'b1, mk(3'd0, 0, 1, 1, 0, 0, 2'b00, 1, 0, 0, 0));
        push(1'b0, mk(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        case (op)
            4'h1, 4'h3, 4'h4, 4'h5: begin
                a = (op == 4'h1) ? 3'd1 : (op == 4'h3) ? 3'd2 : (op == 4'h4) ? 3'd3 : 3'd4;
                for (int i = 0; i < ow; i++) push(1'b0, mk(3'd0, 0, 0, 0, 0, 1, 2'b00, 1, 0, 0, 0));
                push(1'b1, mk(a, 1, 0, 0, 0, 1, 2'b00, 1, 0, 0, 0));
                mz = zf;
            end
            4'h2: begin
                for (int i = 0; i < ow; i++) push(1'b0, mk(3'd0, 0, 0, 0, 0, 1, 2'b01, 0, 1, 0, 0));
                push(1'b1, mk(3'd0, 0, 0, 0, 0, 1, 2'b01, 0, 1, 0, 0));
            end
            4'h6: begin push(1'b0, mk(3'd5, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0)); mz = zf; end
            4'h7: begin push(1'b0, mk(3'd6, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0)); mz = zf; end
            4'h8: push(1'b0, mk(3'd0, 0, 0, 0, 1, 0, 2'b11, 0, 0, 0, 0));
            4'h9: push(1'b0, mk(3'd0, 0, 0, 0, mz, 0, 2'b11, 0, 0, 0, 0));
            4'hA: push(1'b0, mk(3'd0, 0, 0, 0, !mz, 0, 2'b11, 0, 0, 0, 0));
            4'h0: push(1'b0, mk(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
            4'hF: for (int i = 0; i < 100; i++) push(i[0], mk(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0));
            default: push(1'b0, mk(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
        endcase
    endtask

    // Entered just after a rising edge; Zflag is random except where AC is written.
    task automatic run_n(int n);
        for (int i = 0; i < n; i++) begin
            ifc.mem_ready = trace[i].mr;
            ifc.opcode    = cur_op;
            ifc.Zflag     = trace[i].exp.ac_we ? cur_zf : 1'($urandom_range(0, 1));
            @(negedge clk);
            check("trace", sample(), trace[i].exp);
            if (ifc.pc_load) pl_cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_instr(logic [3:0] op, int fw, int ow, logic zf);
        cur_op = op;
        cur_zf = zf;
        build(op, fw, ow, zf);
        run_n(trace.size());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mz    = 1'b0;
        mbe   = 1'b0;
        @(negedge clk);
        check("reset_outputs", sample(), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{op: 4'h3, fw: 0,  ow: 2,  zf: 1'b0, exp_z: 1'b0, exp_pl: 0};
        vecs[1]  = '{op: 4'h7, fw: 0,  ow: 0,  zf: 1'b1, exp_z: 1'b1, exp_pl: 0};
        vecs[2]  = '{op: 4'h9, fw: 0,  ow: 0,  zf: 1'b0, exp_z: 1'b1, exp_pl: 1};
        vecs[3]  = '{op: 4'h6, fw: 1,  ow: 0,  zf: 1'b0, exp_z: 1'b0, exp_pl: 0};
        vecs[4]  = '{op: 4'h9, fw: 0,  ow: 0,  zf: 1'b1, exp_z: 1'b0, exp_pl: 0};
        vecs[5]  = '{op: 4'hA, fw: 0,  ow: 0,  zf: 1'b1, exp_z: 1'b0, exp_pl: 1};
        vecs[6]  = '{op: 4'h2, fw: 0,  ow: 0,  zf: 1'b1, exp_z: 1'b0, exp_pl: 0};
        vecs[7]  = '{op: 4'hB, fw: 0,  ow: 0,  zf: 1'b1, exp_z: 1'b0, exp_pl: 0};
        vecs[8]  = '{op: 4'h8, fw: 16, ow: 0,  zf: 1'b1, exp_z: 1'b0, exp_pl: 1};
        vecs[9]  = '{op: 4'h1, fw: 0,  ow: 16, zf: 1'b1, exp_z: 1'b1, exp_pl: 0};
        vecs[10] = '{op: 4'h4, fw: 1,  ow: 1,  zf: 1'b0, exp_z: 1'b0, exp_pl: 0};
        vecs[11] = '{op: 4'h5, fw: 0,  ow: 3,  zf: 1'b1, exp_z: 1'b1, exp_pl: 0};
        vecs[12] = '{op: 4'h0, fw: 2,  ow: 0,  zf: 1'b0, exp_z: 1'b1, exp_pl: 0};
        vecs[13] = '{op: 4'hA, fw: 0,  ow: 0,  zf: 1'b0, exp_z: 1'b1, exp_pl: 0};

        ifc.mem_ready = 1'b0;
        ifc.opcode    = 4'h0;
        ifc.Zflag     = 1'b0;
        cur_op        = 4'h0;
        cur_zf        = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        foreach (vecs[i]) begin
            pl_cnt = 0;
            do_instr(vecs[i].op, vecs[i].fw, vecs[i].ow, vecs[i].zf);
            check_int("z_after", int'(ifc.z_latched), int'(vecs[i].exp_z));
            check_int("pc_load_count", pl_cnt, vecs[i].exp_pl);
        end

        // HALT holds for 100 cycles of toggling mem_ready
        do_instr(4'hF, 0, 0, 1'b0);
        do_reset();

        // Fetch timeout: 16 wait cycles tolerated, error when the counter reaches the limit
        cur_op = 4'h0;
        trace.delete();
        for (int i = 0; i < 17; i++) push(1'b0, mk(3'd0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0));
        mbe = 1'b1;
        for (int i = 0; i < 6; i++) push(i[0], mk(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0));
        run_n(trace.size());
        check_int("bus_error_sticky", int'(ifc.bus_error), 1);
        do_reset();

        // Operand-read timeout
        cur_op = 4'h3;
        cur_zf = 1'b0;
        build(4'h3, 0, 17, 1'b0);
        trace.pop_back();
        mbe = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b1, mk(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0));
        run_n(trace.size());
        do_reset();

        // Asynchronous reset mid-OPRD with z_latched set
        do_instr(4'h7, 0, 0, 1'b1);
        check_int("z_set_before_reset", int'(ifc.z_latched), 1);
        cur_op = 4'h3;
        build(4'h3, 0, 5, 1'b0);
        run_n(3);
        ifc.mem_ready = 1'b0;
        #2;
        reset = 1'b1;
        mz    = 1'b0;
        mbe   = 1'b0;
        #1;
        check("async_reset", sample(), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_instr(4'h0, 1, 0, 1'b0);

        // Random instruction stream against the trace model
        for (int n = 0; n < 60; n++) begin
            logic [3:0] op;
            int fw, ow;
            op = 4'($urandom_range(0, 14));
            fw = $urandom_range(0, 3);
            ow = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) fw = 16;
            if ($urandom_range(0, 9) == 0) ow = 16;
            do_instr(op, fw, ow, 1'($urandom_range(0, 1)));
        end
        do_instr(4'hF, 1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
